// File: rtl/dac_spi_frame_capture_pkg.sv
// Shared DAC link constants: frame layout and capture FSM encodings.
package dac_spi_frame_capture_pkg;

  localparam int DL_FRAME_BITS = 24;
  localparam int DL_DATA_BITS  = 16;
  localparam int DL_CMD_MSB    = 23;
  localparam int DL_CMD_LSB    = 16;
  localparam int DL_NUM_CH     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } cap_state_t;

  typedef struct packed {
    logic [DL_CMD_MSB-DL_CMD_LSB:0] cmd;
    logic [DL_DATA_BITS-1:0]        data;
  } dac_frame_t;

  // Splits a raw deserialised word into its command and data fields.
  function automatic dac_frame_t split_frame(input logic [DL_FRAME_BITS-1:0] w);
    dac_frame_t f;
    f.cmd  = w[DL_CMD_MSB:DL_CMD_LSB];
    f.data = w[DL_DATA_BITS-1:0];
    return f;
  endfunction

endpackage

// File: rtl/dac_spi_frame_capture_line_sync_edge.sv
// N-stage synchroniser for one serial-link line, plus a history flop
// that yields single-cycle rise/fall pulses on the synchronised level.
module line_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_hist;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_hist <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_line};
      r_hist <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  =  o_level & ~r_hist;
  assign o_fall  = ~o_level &  r_hist;

endmodule

// File: rtl/dac_spi_frame_capture.sv
// Receive side of the DAC serial link: oversampled SYNC/SCLK/DIN capture,
// frame deserialiser, per-channel shadow registers and error accounting.
module dac_spi_frame_capture
  import dac_spi_frame_capture_pkg::*;
#(
  parameter int FRAME_BITS  = DL_FRAME_BITS,
  parameter int DATA_BITS   = DL_DATA_BITS,
  parameter int NUM_CH      = DL_NUM_CH,
  parameter int SYNC_STAGES = 2,
  localparam int CMD_BITS   = FRAME_BITS - DATA_BITS,
  localparam int CH_W       = $clog2(NUM_CH)
) (
  input  logic                 dataclk,
  input  logic                 reset_n,
  input  logic                 DAC_SYNC,
  input  logic                 DAC_SCLK,
  input  logic                 DAC_DIN,
  input  logic                 capture_en,
  input  logic [CH_W-1:0]      ch_sel,
  output logic                 frame_valid,
  output logic [CMD_BITS-1:0]  frame_cmd,
  output logic [DATA_BITS-1:0] frame_data,
  output logic [DATA_BITS-1:0] ch_value,
  output logic                 frame_err,
  output logic [7:0]           err_count,
  output logic [15:0]          frame_count
);

  localparam int                CNT_W    = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  logic w_sync_lvl, w_sync_rise, w_sync_fall;
  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_din_lvl,  w_din_rise,  w_din_fall;
  logic w_unused;

  // Idle line: SYNC high, SCLK high, DIN low.
  line_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync (
    .i_clk(dataclk), .i_rst_n(reset_n), .i_line(DAC_SYNC),
    .o_level(w_sync_lvl), .o_rise(w_sync_rise), .o_fall(w_sync_fall)
  );

  line_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk (
    .i_clk(dataclk), .i_rst_n(reset_n), .i_line(DAC_SCLK),
    .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  line_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_din (
    .i_clk(dataclk), .i_rst_n(reset_n), .i_line(DAC_DIN),
    .o_level(w_din_lvl), .o_rise(w_din_rise), .o_fall(w_din_fall)
  );

  assign w_unused = ^{w_sync_lvl, w_sclk_lvl, w_sclk_rise, w_din_rise, w_din_fall};

  cap_state_t                         r_state, w_state_nxt;
  logic [FRAME_BITS-1:0]              r_shifter;
  logic [CNT_W-1:0]                   r_bit_cnt;
  logic [NUM_CH-1:0][DATA_BITS-1:0]   r_shadow;
  logic                               w_start, w_shift, w_good, w_bad;
  logic [CH_W-1:0]                    w_wr_ch;

  always_ff @(posedge dataclk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_sync_fall && capture_en) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_sync_rise)               w_state_nxt = ST_DONE;
      ST_DONE:                                 w_state_nxt = ST_IDLE;
      default:                                 w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_start = (r_state == ST_IDLE)  && w_sync_fall && capture_en;
    w_shift = (r_state == ST_SHIFT) && w_sclk_fall;
    w_good  = (r_state == ST_DONE)  && (r_bit_cnt == CNT_FULL);
    w_bad   = (r_state == ST_DONE)  && (r_bit_cnt != CNT_FULL);
  end

  assign w_wr_ch = r_shifter[DATA_BITS +: CH_W];

  // An SCLK fall coinciding with the SYNC rise is still shifted in here,
  // since DONE is evaluated one cycle later on the updated count.
  always_ff @(posedge dataclk or negedge reset_n) begin
    if (!reset_n) begin
      r_shifter <= '0;
      r_bit_cnt <= '0;
    end else if (w_start) begin
      r_shifter <= '0;
      r_bit_cnt <= '0;
    end else if (w_shift) begin
      r_shifter <= {r_shifter[FRAME_BITS-2:0], w_din_lvl};
      if (r_bit_cnt != CNT_SAT) r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge dataclk or negedge reset_n) begin
    if (!reset_n) begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_cmd   <= '0;
      frame_data  <= '0;
      frame_count <= '0;
      err_count   <= '0;
      r_shadow    <= '0;
    end else begin
      frame_valid <= w_good;
      frame_err   <= w_bad;
      if (w_good) begin
        frame_cmd         <= r_shifter[FRAME_BITS-1:DATA_BITS];
        frame_data        <= r_shifter[DATA_BITS-1:0];
        r_shadow[w_wr_ch] <= r_shifter[DATA_BITS-1:0];
        frame_count       <= frame_count + 1'b1;
      end
      if (w_bad && err_count != 8'hFF) err_count <= err_count + 1'b1;
    end
  end

  assign ch_value = r_shadow[ch_sel];

endmodule

// File: tb/tb_dac_spi_frame_capture.sv
// Directed bench for dac_spi_frame_capture: SYNC-framed serial BFM with
// hand-computed expected command/data/shadow/counter values.
module tb_dac_spi_frame_capture;

  logic        dataclk = 1'b0;
  logic        reset_n;
  logic        DAC_SYNC, DAC_SCLK, DAC_DIN, capture_en;
  logic [2:0]  ch_sel;
  logic        frame_valid, frame_err;
  logic [7:0]  frame_cmd, err_count;
  logic [15:0] frame_data, ch_value, frame_count;

  int checks = 0;
  int errors = 0;
  int n_valid = 0, n_err = 0, n_both = 0;

  dac_spi_frame_capture dut (
    .dataclk(dataclk), .reset_n(reset_n),
    .DAC_SYNC(DAC_SYNC), .DAC_SCLK(DAC_SCLK), .DAC_DIN(DAC_DIN),
    .capture_en(capture_en), .ch_sel(ch_sel),
    .frame_valid(frame_valid), .frame_cmd(frame_cmd), .frame_data(frame_data),
    .ch_value(ch_value), .frame_err(frame_err), .err_count(err_count),
    .frame_count(frame_count)
  );

  always #5 dataclk = ~dataclk;

  always @(negedge dataclk) begin
    if (frame_valid) n_valid++;
    if (frame_err)   n_err++;
    if (frame_valid && frame_err) n_both++;
  end

  task automatic clks(input int n);
    repeat (n) @(negedge dataclk);
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    clks(2);
    reset_n = 1'b1;
    clks(2);
  endtask

  task automatic start_frame;
    DAC_SYNC = 1'b0;
    clks(4);
  endtask

  task automatic send_bit(input logic b);
    DAC_DIN  = b;
    DAC_SCLK = 1'b1;
    clks(4);
    DAC_SCLK = 1'b0;
    clks(4);
  endtask

  // lat = number of edges from the first one sampling SYNC=1 to the pulse.
  task automatic end_frame(output int lat);
    DAC_SCLK = 1'b1;
    DAC_DIN  = 1'b0;
    clks(4);
    DAC_SYNC = 1'b1;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge dataclk);
      if ((frame_valid || frame_err) && lat == 0) lat = k;
    end
  endtask

  task automatic send_frame(input logic [23:0] w, input int nbits, output int lat);
    start_frame();
    for (int i = 0; i < nbits; i++) send_bit(i < 24 ? w[23-i] : 1'b0);
    end_frame(lat);
  endtask

  task automatic test_reset;
    checks++; if (frame_valid !== 1'b0)  begin errors++; $display("FAIL rst_valid got %0h exp 0", frame_valid); end
    checks++; if (frame_err !== 1'b0)    begin errors++; $display("FAIL rst_err got %0h exp 0", frame_err); end
    checks++; if (frame_cmd !== 8'h00)   begin errors++; $display("FAIL rst_cmd got %h exp 00", frame_cmd); end
    checks++; if (frame_data !== 16'h0)  begin errors++; $display("FAIL rst_data got %h exp 0000", frame_data); end
    checks++; if (ch_value !== 16'h0)    begin errors++; $display("FAIL rst_chval got %h exp 0000", ch_value); end
    checks++; if (err_count !== 8'h00)   begin errors++; $display("FAIL rst_errcnt got %h exp 00", err_count); end
    checks++; if (frame_count !== 16'h0) begin errors++; $display("FAIL rst_fcnt got %h exp 0000", frame_count); end
    reset_n = 1'b1;
    clks(4);
  endtask

  task automatic test_good_frame;
    int lat, v0;
    v0 = n_valid;
    send_frame(24'h18_8000, 24, lat);
    ch_sel = 3'd0;
    clks(1);
    checks++; if (lat != 4)                begin errors++; $display("FAIL good_latency got %0d exp 4", lat); end
    checks++; if (n_valid - v0 != 1)       begin errors++; $display("FAIL good_pulses got %0d exp 1", n_valid - v0); end
    checks++; if (frame_cmd !== 8'h18)     begin errors++; $display("FAIL good_cmd got %h exp 18", frame_cmd); end
    checks++; if (frame_data !== 16'h8000) begin errors++; $display("FAIL good_data got %h exp 8000", frame_data); end
    checks++; if (ch_value !== 16'h8000)   begin errors++; $display("FAIL good_shadow0 got %h exp 8000", ch_value); end
    checks++; if (frame_count !== 16'd1)   begin errors++; $display("FAIL good_fcnt got %0d exp 1", frame_count); end
  endtask

  task automatic test_word_1234;
    int lat;
    send_frame(24'h05_1234, 24, lat);
    ch_sel = 3'd5;
    clks(1);
    checks++; if (frame_data !== 16'h1234) begin errors++; $display("FAIL w1234_data got %h exp 1234", frame_data); end
    checks++; if (ch_value !== 16'h1234)   begin errors++; $display("FAIL w1234_shadow5 got %h exp 1234", ch_value); end
    checks++; if (frame_count !== 16'd2)   begin errors++; $display("FAIL w1234_fcnt got %0d exp 2", frame_count); end
    ch_sel = 3'd0;
    #1;
    checks++; if (ch_value !== 16'h8000)   begin errors++; $display("FAIL w1234_shadow0 got %h exp 8000", ch_value); end
  endtask

  task automatic test_short;
    int lat, v0, e0;
    v0 = n_valid; e0 = n_err;
    send_frame(24'h09_5555, 23, lat);
    ch_sel = 3'd1;
    clks(1);
    checks++; if (n_err - e0 != 1)         begin errors++; $display("FAIL short_errpulse got %0d exp 1", n_err - e0); end
    checks++; if (n_valid != v0)           begin errors++; $display("FAIL short_validpulse got %0d exp 0", n_valid - v0); end
    checks++; if (err_count !== 8'd1)      begin errors++; $display("FAIL short_errcnt got %0d exp 1", err_count); end
    checks++; if (frame_cmd !== 8'h05)     begin errors++; $display("FAIL short_cmd got %h exp 05", frame_cmd); end
    checks++; if (frame_data !== 16'h1234) begin errors++; $display("FAIL short_data got %h exp 1234", frame_data); end
    checks++; if (frame_count !== 16'd2)   begin errors++; $display("FAIL short_fcnt got %0d exp 2", frame_count); end
    checks++; if (ch_value !== 16'h0000)   begin errors++; $display("FAIL short_shadow1 got %h exp 0000", ch_value); end
  endtask

  task automatic test_overlong;
    int lat, e0;
    do_reset();
    e0 = n_err;
    send_frame(24'h06_7777, 25, lat);
    ch_sel = 3'd6;
    clks(1);
    checks++; if (n_err - e0 != 1)       begin errors++; $display("FAIL long_errpulse got %0d exp 1", n_err - e0); end
    checks++; if (err_count !== 8'd1)    begin errors++; $display("FAIL long_errcnt got %0d exp 1", err_count); end
    checks++; if (ch_value !== 16'h0000) begin errors++; $display("FAIL long_shadow6 got %h exp 0000", ch_value); end
    send_frame(24'h03_ABCD, 24, lat);
    ch_sel = 3'd3;
    clks(1);
    checks++; if (ch_value !== 16'hABCD) begin errors++; $display("FAIL long_shadow3 got %h exp ABCD", ch_value); end
    checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL long_fcnt got %0d exp 1", frame_count); end
  endtask

  task automatic test_reset_mid_frame;
    int lat, e0;
    logic [23:0] w;
    w = 24'h04_F0F0;
    start_frame();
    for (int i = 0; i < 10; i++) send_bit(w[23-i]);
    reset_n = 1'b0;
    ch_sel  = 3'd3;
    clks(1);
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL midrst_fcnt got %0d exp 0", frame_count); end
    checks++; if (err_count !== 8'd0)    begin errors++; $display("FAIL midrst_errcnt got %0d exp 0", err_count); end
    checks++; if (ch_value !== 16'h0)    begin errors++; $display("FAIL midrst_shadow3 got %h exp 0000", ch_value); end
    checks++; if (frame_cmd !== 8'h0)    begin errors++; $display("FAIL midrst_cmd got %h exp 00", frame_cmd); end
    DAC_SYNC = 1'b1;
    DAC_SCLK = 1'b1;
    clks(4);
    e0 = n_err;
    reset_n = 1'b1;
    clks(10);
    checks++; if (n_err != e0)           begin errors++; $display("FAIL midrst_errpulse got %0d exp 0", n_err - e0); end
    send_frame(24'h01_00FF, 24, lat);
    ch_sel = 3'd1;
    clks(1);
    checks++; if (ch_value !== 16'h00FF) begin errors++; $display("FAIL midrst_shadow1 got %h exp 00FF", ch_value); end
    checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL midrst_fcnt2 got %0d exp 1", frame_count); end
    checks++; if (err_count !== 8'd0)    begin errors++; $display("FAIL midrst_errcnt2 got %0d exp 0", err_count); end
  endtask

  task automatic test_capture_en;
    int lat, v0, e0;
    v0 = n_valid; e0 = n_err;
    capture_en = 1'b0;
    send_frame(24'h02_BEEF, 24, lat);
    capture_en = 1'b1;
    ch_sel = 3'd2;
    clks(1);
    checks++; if (n_valid != v0 || n_err != e0) begin errors++; $display("FAIL capen_pulses got %0d/%0d exp 0/0", n_valid - v0, n_err - e0); end
    checks++; if (frame_count !== 16'd1)  begin errors++; $display("FAIL capen_fcnt got %0d exp 1", frame_count); end
    checks++; if (err_count !== 8'd0)     begin errors++; $display("FAIL capen_errcnt got %0d exp 0", err_count); end
    checks++; if (ch_value !== 16'h0000)  begin errors++; $display("FAIL capen_shadow2 got %h exp 0000", ch_value); end
  endtask

  task automatic test_back_to_back;
    int lat, v0;
    v0 = n_valid;
    send_frame(24'h02_1111, 24, lat);
    send_frame(24'h07_2222, 24, lat);
    ch_sel = 3'd2;
    clks(1);
    checks++; if (n_valid - v0 != 2)     begin errors++; $display("FAIL b2b_pulses got %0d exp 2", n_valid - v0); end
    checks++; if (ch_value !== 16'h1111) begin errors++; $display("FAIL b2b_shadow2 got %h exp 1111", ch_value); end
    ch_sel = 3'd7;
    #1;
    checks++; if (ch_value !== 16'h2222) begin errors++; $display("FAIL b2b_shadow7 got %h exp 2222", ch_value); end
    checks++; if (frame_count !== 16'd3) begin errors++; $display("FAIL b2b_fcnt got %0d exp 3", frame_count); end
    checks++; if (frame_cmd !== 8'h07)   begin errors++; $display("FAIL b2b_cmd got %h exp 07", frame_cmd); end
  endtask

  task automatic test_err_saturate;
    int lat;
    do_reset();
    for (int i = 0; i < 254; i++) send_frame(24'h0, 0, lat);
    checks++; if (err_count !== 8'hFE)   begin errors++; $display("FAIL sat_errcnt254 got %h exp FE", err_count); end
    send_frame(24'h0, 0, lat);
    checks++; if (err_count !== 8'hFF)   begin errors++; $display("FAIL sat_errcnt255 got %h exp FF", err_count); end
    send_frame(24'h0, 0, lat);
    checks++; if (err_count !== 8'hFF)   begin errors++; $display("FAIL sat_errcnt256 got %h exp FF", err_count); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL sat_fcnt got %0d exp 0", frame_count); end
  endtask

  initial begin
    reset_n    = 1'b0;
    DAC_SYNC   = 1'b1;
    DAC_SCLK   = 1'b1;
    DAC_DIN    = 1'b0;
    capture_en = 1'b1;
    ch_sel     = 3'd0;
    clks(3);
    test_reset();
    test_good_frame();
    test_word_1234();
    test_short();
    test_overlong();
    test_reset_mid_frame();
    test_capture_en();
    test_back_to_back();
    test_err_saturate();
    checks++; if (n_both != 0) begin errors++; $display("FAIL valid_err_overlap got %0d exp 0", n_both); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
